// File: rtl/apb2axi_rd_buf_pkg.sv
// Shared types and constants for the APB-to-AXI read-data buffer.
package apb2axi_rd_buf_pkg;

    localparam int TAG_NUM_DEF       = 16;
    localparam int MAX_BEATS_DEF     = 16;
    localparam int AXI_DATA_W_DEF    = 64;
    localparam int APB_DATA_W_DEF    = 32;

    // Number of APB-sized words carried by one AXI R beat.
    localparam int RD_WORDS_PER_BEAT = AXI_DATA_W_DEF / APB_DATA_W_DEF;

    localparam int TAG_W_DEF  = $clog2(TAG_NUM_DEF);
    localparam int PTR_W_DEF  = $clog2(MAX_BEATS_DEF) + 1;
    localparam int RPTR_W_DEF = $clog2(MAX_BEATS_DEF * RD_WORDS_PER_BEAT) + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One read-data-FIFO entry; tag occupies the MSBs, resp the LSBs.
    typedef struct packed {
        logic [TAG_W_DEF-1:0]      tag;
        logic [AXI_DATA_W_DEF-1:0] data;
        logic                      last;
        logic [1:0]                resp;
    } rdf_entry_t;

    // Per-tag bookkeeping context.
    typedef struct packed {
        logic [PTR_W_DEF-1:0]  wr_ptr;
        logic [RPTR_W_DEF-1:0] rd_ptr;
        logic [1:0]            resp;
        logic                  overflow;
        logic                  done;
    } rdbuf_ctx_t;

    // A tag that lost beats is reported as SLVERR regardless of what it latched.
    function automatic logic [1:0] drain_resp(logic [1:0] resp, logic overflow);
        return overflow ? RESP_SLVERR : resp;
    endfunction

endpackage

// File: rtl/apb2axi_rdbuf_tag_ctx.sv
// Per-tag counters and flags: write pointer, drain pointer, sticky
// response, sticky overflow and the done flag.
module apb2axi_rdbuf_tag_ctx
    import apb2axi_rd_buf_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int RATIO     = RD_WORDS_PER_BEAT,
    parameter int PTR_W     = $clog2(MAX_BEATS) + 1,
    parameter int RP_W      = $clog2(MAX_BEATS * RATIO) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic             wr_last_i,
    input  logic [1:0]       wr_resp_i,
    input  logic             rd_en_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [RP_W-1:0]  rd_ptr_o,
    output logic [1:0]       resp_o,
    output logic             overflow_o,
    output logic             done_o,
    output logic             last_word_o
);
    localparam int RSH = $clog2(RATIO);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]       resp_q, resp_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             full;
    logic [RP_W-1:0]  last_idx;

    assign full        = (wr_ptr_q == PTR_W'(MAX_BEATS));
    // Index of the final word: beat count times words per beat, minus one.
    assign last_idx    = (RP_W'(wr_ptr_q) << RSH) - RP_W'(1);
    assign last_word_o = done_q && (rd_ptr_q == last_idx);

    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign resp_o     = resp_q;
    assign overflow_o = ovf_q;
    assign done_o     = done_q;

    // Next-state: beat capture on write, pointer advance or release on drain.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        resp_d   = resp_q;
        ovf_d    = ovf_q;
        done_d   = done_q;
        if (wr_en_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (resp_q == RESP_OKAY && wr_resp_i != RESP_OKAY) begin
                resp_d = wr_resp_i;
            end
            if (wr_last_i) begin
                done_d = 1'b1;
            end
        end
        // Writes and drains never target the same tag: a done tag refuses beats.
        if (rd_en_i) begin
            if (last_word_o) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                resp_d   = RESP_OKAY;
                ovf_d    = 1'b0;
                done_d   = 1'b0;
            end else begin
                rd_ptr_d = rd_ptr_q + RP_W'(1);
            end
        end
    end

    // Context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            resp_q   <= RESP_OKAY;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            resp_q   <= resp_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/apb2axi_rd_buf.sv
// Per-tag AXI read-data buffer drained one APB word at a time.
// Handshake: an entry is transferred on a clock edge where in_valid and
// in_ready are both high; in_ready depends only on the entry's tag (a done
// tag refuses beats) and never on in_valid. rd_req is a one-cycle request
// answered by rd_valid exactly one cycle later; requests may be issued
// every cycle.
module apb2axi_rd_buf
    import apb2axi_rd_buf_pkg::*;
#(
    parameter int  TAG_NUM    = TAG_NUM_DEF,
    parameter int  MAX_BEATS  = MAX_BEATS_DEF,
    parameter int  AXI_DATA_W = AXI_DATA_W_DEF,
    parameter int  APB_DATA_W = APB_DATA_W_DEF,
    localparam int TAG_W      = $clog2(TAG_NUM),
    localparam int RDF_W      = TAG_W + AXI_DATA_W + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RDF_W-1:0]      in_entry,
    input  logic                  rd_req,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic [APB_DATA_W-1:0] rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_last,
    output logic                  rd_err,
    output logic [TAG_NUM-1:0]    done_vec,
    output logic                  free_pulse,
    output logic [TAG_W-1:0]      free_tag
);
    localparam int RATIO  = AXI_DATA_W / APB_DATA_W;
    localparam int RSH    = $clog2(RATIO);
    localparam int PTR_W  = $clog2(MAX_BEATS) + 1;
    localparam int RP_W   = $clog2(MAX_BEATS * RATIO) + 1;
    localparam int DEPTH  = TAG_NUM * MAX_BEATS;
    localparam int ADDR_W = $clog2(DEPTH);

    // Entry fields, same layout as rdf_entry_t.
    logic [TAG_W-1:0]      in_tag;
    logic [AXI_DATA_W-1:0] in_data;
    logic                  in_last;
    logic [1:0]            in_resp;

    assign in_tag  = in_entry[RDF_W-1 -: TAG_W];
    assign in_data = in_entry[AXI_DATA_W+2 -: AXI_DATA_W];
    assign in_last = in_entry[2];
    assign in_resp = in_entry[1:0];

    logic [PTR_W-1:0] wr_ptr_a    [TAG_NUM];
    logic [RP_W-1:0]  rd_ptr_a    [TAG_NUM];
    logic [1:0]       resp_a      [TAG_NUM];
    logic             ovf_a       [TAG_NUM];
    logic             last_word_a [TAG_NUM];

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];

    logic accept, store_en, rd_hit, rd_release;

    assign in_ready   = !done_vec[in_tag];
    assign accept     = in_valid && in_ready && !rst;
    assign store_en   = accept && (wr_ptr_a[in_tag] != PTR_W'(MAX_BEATS));
    assign rd_hit     = rd_req && !rst && done_vec[rd_tag];
    assign rd_release = rd_hit && last_word_a[rd_tag];

    for (genvar g = 0; g < TAG_NUM; g++) begin : g_tag
        apb2axi_rdbuf_tag_ctx #(
            .MAX_BEATS (MAX_BEATS),
            .RATIO     (RATIO),
            .PTR_W     (PTR_W),
            .RP_W      (RP_W)
        ) u_ctx (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (accept && (in_tag == TAG_W'(g))),
            .wr_last_i   (in_last),
            .wr_resp_i   (in_resp),
            .rd_en_i     (rd_hit && (rd_tag == TAG_W'(g))),
            .wr_ptr_o    (wr_ptr_a[g]),
            .rd_ptr_o    (rd_ptr_a[g]),
            .resp_o      (resp_a[g]),
            .overflow_o  (ovf_a[g]),
            .done_o      (done_vec[g]),
            .last_word_o (last_word_a[g])
        );
    end

    // Storage addressing: each tag owns MAX_BEATS consecutive beat slots.
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [RP_W-1:0]       rd_ptr_sel, word_idx;
    logic [APB_DATA_W-1:0] rd_word;

    assign wr_addr    = ADDR_W'(in_tag) * ADDR_W'(MAX_BEATS) + ADDR_W'(wr_ptr_a[in_tag]);
    assign rd_ptr_sel = rd_ptr_a[rd_tag];
    assign rd_addr    = ADDR_W'(rd_tag) * ADDR_W'(MAX_BEATS) + ADDR_W'(rd_ptr_sel >> RSH);
    assign word_idx   = rd_ptr_sel & RP_W'(RATIO - 1);
    // Word 0 is the least significant slice of the beat.
    assign rd_word    = APB_DATA_W'(mem_q[rd_addr] >> (int'(word_idx) * APB_DATA_W));

    // Beat storage: data only, no reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_q[wr_addr] <= in_data;
        end
    end

    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q, rd_err_d;
    logic                  rd_last_q, rd_last_d;
    logic                  free_pulse_q, free_pulse_d;
    logic [TAG_W-1:0]      free_tag_q, free_tag_d;
    logic [APB_DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]            rd_resp_q, rd_resp_d;

    // Drain response: data and response only for done tags, zero otherwise.
    always_comb begin
        rd_valid_d   = rd_req;
        rd_err_d     = rd_req && !done_vec[rd_tag];
        rd_last_d    = rd_release;
        free_pulse_d = rd_release;
        free_tag_d   = rd_release ? rd_tag : free_tag_q;
        rd_data_d    = '0;
        rd_resp_d    = RESP_OKAY;
        if (rd_hit) begin
            rd_data_d = rd_word;
            rd_resp_d = drain_resp(resp_a[rd_tag], ovf_a[rd_tag]);
        end
    end

    // Registered drain outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            free_pulse_q <= 1'b0;
            free_tag_q   <= '0;
            rd_data_q    <= '0;
            rd_resp_q    <= RESP_OKAY;
        end else begin
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_last_q    <= rd_last_d;
            free_pulse_q <= free_pulse_d;
            free_tag_q   <= free_tag_d;
            rd_data_q    <= rd_data_d;
            rd_resp_q    <= rd_resp_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_last    = rd_last_q;
    assign free_pulse = free_pulse_q;
    assign free_tag   = free_tag_q;
    assign rd_data    = rd_data_q;
    assign rd_resp    = rd_resp_q;

endmodule
